mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Initiator-side load/store unit for the single-cycle-read, posedge-write word data memory (1024 x 32, word-indexed by addr[11:2]).
- Accepts one CPU memory op at a time: LW/LH/LHU/LB/LBU/SW/SH/SB.
- Generates the memory's addr/we/re/wd signals and performs read-modify-write for sub-word stores, since the memory only writes whole words.
- Returns extended load data and a misalignment error; sits between the EX/MEM stage and the data memory.

Parameters:
ADDR_W, 32, width of CPU and memory address buses
CHECK_ALIGN, 1, 1 = flag misaligned ops and skip memory access; 0 = force alignment by clearing low address bits

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
req  input  1  op request, sampled only in IDLE
op  input  3  0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU, 5 SW, 6 SH, 7 SB
addr  input  ADDR_W  byte address
wdata  input  32  store data; low byte/half used for SB/SH
busy  output  1  high from accept until done cycle inclusive
done  output  1  one-cycle completion pulse
rdata  output  32  load result, valid while done=1, held afterwards
err  output  1  misaligned flag, valid with done
dm_addr  output  ADDR_W  memory address, always {addr[ADDR_W-1:2],2'b00}
dm_re  output  1  memory read enable
dm_we  output  1  memory write enable
dm_wd  output  32  memory write data
dm_rd  input  32  memory read data, combinational from dm_addr/dm_re

Behaviour:
- Reset state: IDLE. busy=0, done=0, rdata=0, err=0, dm_re=0, dm_we=0, dm_wd=0, dm_addr=0. All internal latches cleared.
- busy, done, rdata and err are registered. dm_* are decoded from the current state and latched registers. No dm_* output is driven from CPU inputs combinationally.
- Little-endian byte lanes:
  - Byte lane k = addr[1:0] occupies bits [8k+7:8k].
  - Halfword at addr[1] occupies bits [16*addr[1]+15:16*addr[1]].
- Alignment:
  - LW/SW require addr[1:0]=00.
  - LH/LHU/SH require addr[0]=0.
  - Bytes are always aligned.
- States: IDLE, LOAD, WRITE, RMW_RD, RMW_WR, DONE.
- IDLE:
  - If req=1, latch op, addr and wdata, and set busy.
  - Misaligned with CHECK_ALIGN=1: go to DONE with err=1 and rdata unchanged; no memory access.
  - Otherwise: loads go to LOAD, SW goes to WRITE, SH/SB go to RMW_RD.
- LOAD: dm_re=1. Capture dm_rd, extract the lane, then sign-extend (LH/LB) or zero-extend (LHU/LBU) into rdata. Go to DONE.
- WRITE: dm_we=1, dm_wd=latched wdata. Go to DONE.
- RMW_RD: dm_re=1. Capture dm_rd into merge register. Go to RMW_WR.
- RMW_WR: dm_we=1, dm_wd = merge register with only the target lane replaced by wdata[7:0] or wdata[15:0]. Go to DONE.
- DONE: done=1, busy=1, err valid. Next state IDLE, where busy drops.
- Latency from the req-sampling edge to done high:
  - Loads and SW: 2 cycles.
  - SH/SB: 3 cycles.
  - Misaligned: 1 cycle.
- Throughput: at most one op in flight. req while busy is ignored and not queued. The CPU holds req until it sees done; a new req is sampled in the IDLE cycle after DONE.
- dm_re and dm_we are never both 1. Both are 0 in IDLE and DONE.
- Reset mid-operation: return to IDLE asynchronously and drop dm_we immediately. An RMW interrupted in RMW_RD performs no write. done does not pulse.
- CHECK_ALIGN=0: err is always 0; the address is truncated to natural alignment before lane selection.

Decomposition:
- Shared package mau_pkg: op encodings (OP_LW..OP_SB), state enum, and helpers is_load/is_store/op_size.
- One sub-module mau_lane, purely combinational: load extraction/extension, and store merge of old word + new data + addr[1:0] + size into the new word.

Test Plan:
- Preload word 0x10 = 0x8877_6655. LB addr 0x13 -> done 2 cycles after req, rdata=0xFFFF_FF88. LBU addr 0x13 -> rdata=0x0000_0088. LH addr 0x12 -> rdata=0xFFFF_8877.
- SB addr 0x11, wdata=0x0000_00AB on word 0x8877_6655 -> RMW_RD then RMW_WR, dm_wd=0x8877_AB55, done at cycle 3. A following LW 0x10 returns 0x8877_AB55.
- SW addr 0x20, wdata=0xDEAD_BEEF -> exactly one dm_we cycle with dm_addr=0x20; no dm_re asserted during the op.
- LW addr 0x22 with CHECK_ALIGN=1 -> done 1 cycle after req, err=1, dm_re and dm_we never asserted. Repeat with CHECK_ALIGN=0 -> err=0, access to 0x20.
- Assert req with a new op while busy during an SH -> ignored; only the first op completes.
- Assert reset during RMW_RD of an SB -> dm_we never asserted, memory unchanged, all outputs 0, next req accepted normally.

Source files
------------

// File: rtl/mau_pkg.sv
// ============================================================================
// Module : mau_pkg
// Brief  : Shared op encodings, FSM states and op-decode helpers for the
//          memory access unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mau_pkg;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_WRITE  = 3'd2,
    ST_RMW_RD = 3'd3,
    ST_RMW_WR = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  function automatic logic is_load(input logic [2:0] op);
    return (op <= OP_LBU);
  endfunction

  function automatic logic is_store(input logic [2:0] op);
    return (op >= OP_SW);
  endfunction

  function automatic size_t op_size(input logic [2:0] op);
    case (op)
      OP_LW, OP_SW:          return SZ_WORD;
      OP_LH, OP_LHU, OP_SH:  return SZ_HALF;
      default:               return SZ_BYTE;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mau_lane.sv
// ============================================================================
// Module : mau_lane
// Brief  : Combinational byte-lane logic: load extraction/extension and
//          sub-word store merge into an existing word.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mau_lane
  import mau_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [1:0]  lane,
  input  size_t       size,
  input  logic        sext,
  input  logic [31:0] new_data,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = rd_word[{lane, 3'b000} +: 8];
  assign w_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_data = rd_word;
    merged    = rd_word;
    case (size)
      SZ_BYTE: begin
        load_data                     = {{24{sext & w_byte[7]}}, w_byte};
        merged[{lane, 3'b000} +: 8]   = new_data[7:0];
      end
      SZ_HALF: begin
        load_data                     = {{16{sext & w_half[15]}}, w_half};
        merged[{lane[1], 4'b0000} +: 16] = new_data[15:0];
      end
      default: begin
        load_data = rd_word;
        merged    = new_data;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module : mem_access_unit
// Brief  : One-op-at-a-time load/store unit for a single-cycle-read word
//          memory; sub-word stores are done as read-modify-write.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_access_unit
  import mau_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              err,
  output logic [ADDR_W-1:0] dm_addr,
  output logic              dm_re,
  output logic              dm_we,
  output logic [31:0]       dm_wd,
  input  logic [31:0]       dm_rd
);

  state_t             r_state;
  state_t             w_next;
  logic [2:0]         r_op;
  logic [ADDR_W-1:0]  r_addr;
  logic [31:0]        r_wdata;
  logic [31:0]        r_merge;
  logic [31:0]        r_rdata;
  logic               r_busy;
  logic               r_done;
  logic               r_err;

  size_t              w_size_in;
  logic               w_misal;
  logic [1:0]         w_lowmask;
  logic               w_bad;
  logic [ADDR_W-1:0]  w_addr_in;
  logic               w_accept;
  logic [31:0]        w_load;
  logic [31:0]        w_merged;

  // Alignment decode on the incoming request
  always_comb begin
    w_size_in = op_size(op);
    w_misal   = 1'b0;
    w_lowmask = 2'b11;
    case (w_size_in)
      SZ_WORD: begin
        w_misal   = |addr[1:0];
        w_lowmask = 2'b00;
      end
      SZ_HALF: begin
        w_misal   = addr[0];
        w_lowmask = 2'b10;
      end
      default: ;
    endcase
  end

  assign w_bad     = CHECK_ALIGN && w_misal;
  // Without checking, the address is silently pulled down to natural alignment
  assign w_addr_in = CHECK_ALIGN ? addr : {addr[ADDR_W-1:2], addr[1:0] & w_lowmask};
  assign w_accept  = (r_state == ST_IDLE) && req;

  mau_lane u_lane (
    .rd_word   (dm_rd),
    .lane      (r_addr[1:0]),
    .size      (op_size(r_op)),
    .sext      ((r_op == OP_LH) || (r_op == OP_LB)),
    .new_data  (r_wdata),
    .load_data (w_load),
    .merged    (w_merged)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req) begin
          if (w_bad)            w_next = ST_DONE;
          else if (is_load(op)) w_next = ST_LOAD;
          else if (op == OP_SW) w_next = ST_WRITE;
          else                  w_next = ST_RMW_RD;
        end
      end
      ST_LOAD, ST_WRITE, ST_RMW_WR: w_next = ST_DONE;
      ST_RMW_RD:                    w_next = ST_RMW_WR;
      ST_DONE:                      w_next = ST_IDLE;
      default:                      w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_op    <= 3'd0;
      r_addr  <= '0;
      r_wdata <= 32'd0;
      r_merge <= 32'd0;
      r_rdata <= 32'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != ST_IDLE);
      r_done  <= (w_next == ST_DONE);
      if (w_accept) begin
        r_op    <= op;
        r_addr  <= w_addr_in;
        r_wdata <= wdata;
        r_err   <= w_bad;
      end
      if (r_state == ST_LOAD)   r_rdata <= w_load;
      if (r_state == ST_RMW_RD) r_merge <= dm_rd;
    end
  end

  // Merge uses the captured old word, so the memory read is not repeated
  logic [31:0] w_rmw_word;
  logic [31:0] w_rmw_unused;
  mau_lane u_merge (
    .rd_word   (r_merge),
    .lane      (r_addr[1:0]),
    .size      (op_size(r_op)),
    .sext      (1'b0),
    .new_data  (r_wdata),
    .load_data (w_rmw_unused),
    .merged    (w_rmw_word)
  );

  always_comb begin
    dm_re = 1'b0;
    dm_we = 1'b0;
    dm_wd = 32'd0;
    case (r_state)
      ST_LOAD, ST_RMW_RD: dm_re = 1'b1;
      ST_WRITE: begin
        dm_we = 1'b1;
        dm_wd = r_wdata;
      end
      ST_RMW_WR: begin
        dm_we = 1'b1;
        dm_wd = w_rmw_word;
      end
      default: ;
    endcase
  end

  assign dm_addr = {r_addr[ADDR_W-1:2], 2'b00};
  assign busy    = r_busy;
  assign done    = r_done;
  assign rdata   = r_rdata;
  assign err     = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// Module : tb_mem_access_unit
// Brief  : Scoreboard bench for mem_access_unit with checked and unchecked
//          alignment instances, each on its own word memory.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

  localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3,
                         LBU = 3'd4, SW = 3'd5, SH = 3'd6, SB = 3'd7;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
    int          nre;
    int          nwe;
    logic [31:0] waddr;
    logic [31:0] wword;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_v;
  logic [2:0]  op;
  logic [31:0] addr, wdata;
  logic [1:0]  busy_v, done_v, err_v, re_v, we_v;
  logic [31:0] rdata_v [2];
  logic [31:0] dm_addr_v [2];
  logic [31:0] wd_v [2];
  logic [31:0] rd_v [2];

  logic [31:0] mem [2][1024];
  logic [31:0] ref_mem [2][1024];
  logic [31:0] last_rd [2];
  int          nre [2];
  int          nwe [2];
  exp_t        q0 [$];
  exp_t        q1 [$];
  int          total = 0;
  int          bad = 0;
  int          cyc_cnt = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32), .CHECK_ALIGN(1'b1)) u_dut (
    .clk(clk), .reset(reset), .req(req_v[1]), .op(op), .addr(addr), .wdata(wdata),
    .busy(busy_v[1]), .done(done_v[1]), .rdata(rdata_v[1]), .err(err_v[1]),
    .dm_addr(dm_addr_v[1]), .dm_re(re_v[1]), .dm_we(we_v[1]), .dm_wd(wd_v[1]),
    .dm_rd(rd_v[1])
  );

  mem_access_unit #(.ADDR_W(32), .CHECK_ALIGN(1'b0)) u_dut_na (
    .clk(clk), .reset(reset), .req(req_v[0]), .op(op), .addr(addr), .wdata(wdata),
    .busy(busy_v[0]), .done(done_v[0]), .rdata(rdata_v[0]), .err(err_v[0]),
    .dm_addr(dm_addr_v[0]), .dm_re(re_v[0]), .dm_we(we_v[0]), .dm_wd(wd_v[0]),
    .dm_rd(rd_v[0])
  );

  assign rd_v[0] = mem[0][dm_addr_v[0][11:2]];
  assign rd_v[1] = mem[1][dm_addr_v[1][11:2]];

  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (we_v[0]) mem[0][dm_addr_v[0][11:2]] <= wd_v[0];
    if (we_v[1]) mem[1][dm_addr_v[1][11:2]] <= wd_v[1];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference behaviour: plain byte-address arithmetic on a word array
  task automatic model(input int i, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] wd, output exp_t e);
    int sz, off, idx;
    logic [31:0] al, word, mask, val;
    sz = (o == LW || o == SW) ? 4 : (o == LH || o == LHU || o == SH) ? 2 : 1;
    al = a - (a % sz);
    e.nre = 0; e.nwe = 0; e.wword = 0; e.err = 1'b0;
    e.waddr = al & 32'hFFFF_FFFC;
    e.rdata = last_rd[i];
    if ((a % sz) != 0 && i == 1) begin
      e.err = 1'b1;
      e.cyc = 1;
      return;
    end
    idx  = int'((al >> 2) & 32'd1023);
    off  = int'(al % 4);
    mask = (sz == 4) ? 32'hFFFF_FFFF : (sz == 2) ? 32'h0000_FFFF : 32'h0000_00FF;
    word = ref_mem[i][idx];
    if (o <= LBU) begin
      val = (word >> (8 * off)) & mask;
      if ((o == LH || o == LB) && val[8 * sz - 1]) val = val | ~mask;
      last_rd[i] = val;
      e.rdata = val;
      e.cyc = 2;
      e.nre = 1;
    end else begin
      if (sz == 4) word = wd;
      else word = (word & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
      ref_mem[i][idx] = word;
      e.wword = word;
      e.nwe = 1;
      e.nre = (sz == 4) ? 0 : 1;
      e.cyc = (sz == 4) ? 2 : 3;
    end
  endtask

  task automatic mon(input int i);
    exp_t e;
    int   depth;
    depth = (i == 1) ? q1.size() : q0.size();
    if (depth > 0) e = (i == 1) ? q1[0] : q0[0];
    if (re_v[i] || we_v[i]) begin
      check($sformatf("re_we_excl%0d", i), {31'd0, re_v[i] & we_v[i]}, 32'd0);
      check($sformatf("access_outstanding%0d", i), depth, 1);
      if (depth > 0) begin
        check($sformatf("dm_addr%0d", i), dm_addr_v[i], e.waddr);
        if (we_v[i]) check($sformatf("dm_wd%0d", i), wd_v[i], e.wword);
      end
      nre[i] += int'(re_v[i]);
      nwe[i] += int'(we_v[i]);
    end
    if (done_v[i]) begin
      check($sformatf("done_outstanding%0d", i), depth, 1);
      if (depth > 0) begin
        if (i == 1) void'(q1.pop_front()); else void'(q0.pop_front());
        check($sformatf("rdata%0d", i), rdata_v[i], e.rdata);
        check($sformatf("err%0d", i), {31'd0, err_v[i]}, {31'd0, e.err});
        check($sformatf("done_cycle%0d", i), cyc_cnt, e.cyc);
        check($sformatf("re_cycles%0d", i), nre[i], e.nre);
        check($sformatf("we_cycles%0d", i), nwe[i], e.nwe);
        check($sformatf("busy_at_done%0d", i), {31'd0, busy_v[i]}, 32'd1);
      end
      nre[i] = 0;
      nwe[i] = 0;
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      mon(0);
      mon(1);
    end
  end

  task automatic do_op(input int i, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] wd, input bit disturb);
    exp_t e;
    int   n;
    @(negedge clk);
    model(i, o, a, wd, e);
    e.cyc += cyc_cnt;
    if (i == 1) q1.push_back(e); else q0.push_back(e);
    op = o; addr = a; wdata = wd;
    req_v[i] = 1'b1;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      n++;
      if (disturb && n == 1) begin
        op = SW; addr = a ^ 32'h40; wdata = ~wd;
      end
      if (done_v[i]) break;
    end
    if (!done_v[i]) begin
      check($sformatf("done_timeout%0d", i), {31'd0, done_v[i]}, 32'd1);
      if (i == 1) q1.delete(); else q0.delete();
    end
    req_v[i] = 1'b0;
    @(posedge clk); #1;
    check($sformatf("busy_after%0d", i), {31'd0, busy_v[i]}, 32'd0);
  endtask

  task automatic check_idle_outputs(input int i, input string tag);
    check({tag, "_busy"},    {31'd0, busy_v[i]}, 32'd0);
    check({tag, "_done"},    {31'd0, done_v[i]}, 32'd0);
    check({tag, "_rdata"},   rdata_v[i], 32'd0);
    check({tag, "_err"},     {31'd0, err_v[i]}, 32'd0);
    check({tag, "_re_we"},   {30'd0, re_v[i], we_v[i]}, 32'd0);
    check({tag, "_dm_wd"},   wd_v[i], 32'd0);
    check({tag, "_dm_addr"}, dm_addr_v[i], 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] v;
    int nmis;
    reset = 1'b1;
    req_v = 2'b00;
    op = LW; addr = 32'd0; wdata = 32'd0;
    for (int i = 0; i < 2; i++) begin
      last_rd[i] = 32'd0;
      nre[i] = 0;
      nwe[i] = 0;
      for (int w = 0; w < 1024; w++) begin
        v = (w == 4) ? 32'h8877_6655 : $urandom;
        mem[i][w] <= v;
        ref_mem[i][w] = v;
      end
    end
    repeat (3) @(negedge clk);
    check_idle_outputs(1, "reset1");
    check_idle_outputs(0, "reset0");
    reset = 1'b0;

    do_op(1, LB,  32'h13, 32'd0, 1'b0);
    do_op(1, LBU, 32'h13, 32'd0, 1'b0);
    do_op(1, LH,  32'h12, 32'd0, 1'b0);
    do_op(1, SB,  32'h11, 32'h0000_00AB, 1'b0);
    do_op(1, LW,  32'h10, 32'd0, 1'b0);
    do_op(1, SW,  32'h20, 32'hDEAD_BEEF, 1'b0);
    do_op(1, LW,  32'h22, 32'd0, 1'b0);
    do_op(0, LW,  32'h22, 32'd0, 1'b0);
    do_op(0, SH,  32'h13, 32'h1234_5678, 1'b0);
    do_op(1, SH,  32'h26, 32'hCAFE_F00D, 1'b1);
    do_op(1, LW,  32'h24, 32'd0, 1'b0);
    do_op(1, LW,  32'h64, 32'd0, 1'b0);

    // Reset while an SB sits in its read phase: no write may follow
    @(negedge clk);
    op = SB; addr = 32'h34; wdata = 32'h0000_0099;
    req_v[1] = 1'b1;
    @(posedge clk); #1;
    check("rmw_rd_reached", {31'd0, re_v[1]}, 32'd1);
    reset = 1'b1;
    #1;
    check_idle_outputs(1, "mid_reset");
    req_v[1] = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;
    check("mem_after_reset", mem[1][13], ref_mem[1][13]);
    do_op(1, LW, 32'h34, 32'd0, 1'b0);

    for (int k = 0; k < 60; k++)
      do_op(1, 3'($urandom_range(0, 7)), ($urandom_range(0, 3) << 12) | $urandom_range(0, 127),
            $urandom, 1'($urandom_range(0, 1)));
    for (int k = 0; k < 30; k++)
      do_op(0, 3'($urandom_range(0, 7)), $urandom_range(0, 127), $urandom, 1'b0);

    for (int i = 0; i < 2; i++) begin
      nmis = 0;
      for (int w = 0; w < 1024; w++)
        if (mem[i][w] !== ref_mem[i][w]) nmis++;
      check($sformatf("mem_final%0d", i), nmis, 0);
    end
    check("queue_drain", q0.size() + q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
